pu_fram_arbiter: RTL and testbench
==================================

Name: pu_fram_arbiter

Overview:
Two-port arbiter that shares one single-port pu_fram instance between two requesters, for example the processor-unit datapath (port 0) and a debug/loader bus (port 1). It grants at most one access per cycle using round-robin and drives the FRAM control signals. It routes read data back to the requester that issued the read, with a tag pipeline. It stalls reads that would hit the FRAM's one-cycle write-commit window (read-after-write hazard).

Parameters:
RAM_SIZE, 16, FRAM depth in words
DATA_WIDTH, 32, data word width
ATTR_WIDTH, 4, attribute width
ADDR_WIDTH, $clog2(RAM_SIZE), address width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req0 / req1  in  1  access request, held until ack
wr0 / wr1  in  1  1 = write, 0 = read
addr0 / addr1  in  ADDR_WIDTH  word address
wdata0 / wdata1  in  DATA_WIDTH  write data
wattr0 / wattr1  in  ATTR_WIDTH  write attribute
ack0 / ack1  out  1  request accepted this cycle (combinational)
rvalid0 / rvalid1  out  1  read response valid (registered)
rdata0 / rdata1  out  DATA_WIDTH  read data, valid while rvalid
rattr0 / rattr1  out  ATTR_WIDTH  read attribute, valid while rvalid
signal_addr  out  ADDR_WIDTH  to FRAM
signal_wr  out  1  to FRAM
signal_oe  out  1  to FRAM
fram_data_in  out  DATA_WIDTH  to FRAM data_in
fram_attr_in  out  ATTR_WIDTH  to FRAM attr_in
fram_data_out  in  DATA_WIDTH  from FRAM data_out
fram_attr_out  in  ATTR_WIDTH  from FRAM attr_out

Behaviour:
- FRAM timing served by this block:
  - A command presented in cycle t is sampled by the FRAM at the edge ending t.
  - Read data appears in cycle t+1.
  - A write commits to the bank at the edge ending t+1.
- Arbitration:
  - Register `last` (1 bit) holds the most recently granted port.
  - Only one requester eligible: grant it.
  - Both eligible: grant port !last.
  - On any grant, `last` <= granted port.
  - ackN = grant to port N in the current cycle. Request fields are used in the same cycle.
- Eligibility:
  - A port is eligible when reqN=1 and no hazard applies to it.
  - Hazard: reqN is a read, the previous cycle issued a write (pw_valid=1), and addrN == pw_addr.
  - A hazarded port is ineligible for that cycle only; the other port may be granted instead.
  - Hazard tracking: pw_valid/pw_addr registers capture every granted write.
- FRAM drive during a granted cycle:
  - signal_addr = addrN.
  - signal_wr = wrN.
  - signal_oe = ~wrN.
  - fram_data_in / fram_attr_in = wdataN / wattrN.
- Idle cycle (no grant):
  - signal_wr = 0, signal_oe = 0, signal_addr = 0.
  - fram_data_in and fram_attr_in are driven 0.
- Response path:
  - Tag registers rd_valid and rd_port capture each granted read.
  - Next cycle: rvalid[rd_port] = 1, and rdata/rattr of that port = fram_data_out / fram_attr_out.
  - Outputs of the non-addressed port read 0.
- Latency: read ack in cycle t gives rvalid in cycle t+1. A write needs no response.
- Throughput: 1 access per cycle. Back-to-back read from the address just written costs exactly 1 stall cycle.
- Reset values:
  - All ack/rvalid = 0; rdata/rattr = 0.
  - last = 1, so port 0 wins the first tie.
  - pw_valid = 0, rd_valid = 0.
- Reset mid-operation:
  - A read granted in the cycle before reset has its response dropped (no rvalid).
  - A write granted in the cycle before reset still commits in the FRAM, which has no reset. This is accepted behaviour.
  - Acks are 0 while rst=1.
- A request dropped before ack is legal and leaves no side effects.

Decomposition:
- Shared package pu_fram_pkg: port-index constants (PORT_DBG=1, PORT_PU=0) and a request struct {wr, addr, data, attr}, reused by future PU controllers.
- Natural sub-module: pu_fram_rr_arb2 (2-way round-robin with eligibility mask and `last` register).
- Hazard check and tag pipeline stay in the top module.

Test Plan:
1. After reset, req0 write addr=3 data=0xDEADBEEF attr=0x5, then req0 read addr=3 the next cycle -> read gets no ack for 1 cycle, acked the cycle after; rvalid0 one cycle later with rdata0=0xDEADBEEF, rattr0=0x5.
2. req0 and req1 both read continuously, addresses 1 and 2 -> acks alternate 0,1,0,1…, port 0 first; each rvalid arrives exactly 1 cycle after its ack, with the correct port data.
3. Port 1 writes addr=7 while port 0 reads addr=7 in the following cycle, and port 1 also requests a read of addr=4 -> port 0 stalled that cycle, port 1 granted; port 0 then returns the new addr 7 value.
4. No requests for 5 cycles -> signal_oe=0, signal_wr=0, all rvalid=0 every cycle.
5. rst asserted the cycle after a read ack on port 1 -> rvalid1 stays 0; after release, the first tie goes to port 0.
6. Write addr=9 followed by a read of addr=10 -> no stall; rvalid on the next cycle.

Source files
------------

// File: rtl/pu_fram_pkg.sv
// Shared definitions for blocks that talk to a pu_fram instance.
package pu_fram_pkg;

  // Requester port indices on the two-port arbiter.
  localparam logic PORT_PU  = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  // Geometry of the default FRAM configuration.
  localparam int unsigned PU_FRAM_ADDR_W = 4;
  localparam int unsigned PU_FRAM_DATA_W = 32;
  localparam int unsigned PU_FRAM_ATTR_W = 4;

  // One FRAM access request at the default geometry.
  typedef struct packed {
    logic                      wr;
    logic [PU_FRAM_ADDR_W-1:0] addr;
    logic [PU_FRAM_DATA_W-1:0] data;
    logic [PU_FRAM_ATTR_W-1:0] attr;
  } pu_fram_req_t;

endpackage

// File: rtl/pu_fram_rr_arb2.sv
// Two-way round-robin arbiter with an eligibility mask.
// Ties go to the port that was not granted most recently; port 0 wins the first tie.
module pu_fram_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] elig_i,
  output logic [1:0] gnt_o,
  output logic       gnt_idx_o
);

  logic last_q, last_d;

  // Pick a winner among eligible ports and remember it.
  always_comb begin
    gnt_o     = 2'b00;
    gnt_idx_o = 1'b0;
    last_d    = last_q;
    unique case (elig_i)
      2'b01: begin
        gnt_o     = 2'b01;
        gnt_idx_o = 1'b0;
      end
      2'b10: begin
        gnt_o     = 2'b10;
        gnt_idx_o = 1'b1;
      end
      2'b11: begin
        gnt_idx_o = ~last_q;
        gnt_o     = last_q ? 2'b01 : 2'b10;
      end
      default: ;
    endcase
    if (|elig_i) last_d = gnt_idx_o;
  end

  // Most recently granted port register.
  always_ff @(posedge clk) begin
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end

endmodule

// File: rtl/pu_fram_arbiter.sv
// Shares one single-port pu_fram between the PU datapath (port 0) and the debug bus (port 1).
// Grants one access per cycle, routes read data back by tag and stalls reads that would
// land in the FRAM's write-commit window.
module pu_fram_arbiter
  import pu_fram_pkg::*;
#(
  parameter int unsigned RAM_SIZE   = 16,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ATTR_WIDTH = 4,
  parameter int unsigned ADDR_WIDTH = $clog2(RAM_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  wr0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [ATTR_WIDTH-1:0] wattr0,
  output logic                  ack0,
  output logic                  rvalid0,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [ATTR_WIDTH-1:0] rattr0,
  input  logic                  req1,
  input  logic                  wr1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  input  logic [ATTR_WIDTH-1:0] wattr1,
  output logic                  ack1,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [ATTR_WIDTH-1:0] rattr1,
  output logic [ADDR_WIDTH-1:0] signal_addr,
  output logic                  signal_wr,
  output logic                  signal_oe,
  output logic [DATA_WIDTH-1:0] fram_data_in,
  output logic [ATTR_WIDTH-1:0] fram_attr_in,
  input  logic [DATA_WIDTH-1:0] fram_data_out,
  input  logic [ATTR_WIDTH-1:0] fram_attr_out
);

  typedef struct packed {
    logic                  wr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [ATTR_WIDTH-1:0] attr;
  } req_t;

  req_t                  port_req [2];
  req_t                  sel;
  logic [1:0]            hazard;
  logic [1:0]            elig;
  logic [1:0]            gnt;
  logic                  gnt_idx;
  logic                  any_gnt;

  logic                  pw_valid_q, pw_valid_d;
  logic [ADDR_WIDTH-1:0] pw_addr_q, pw_addr_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  rd_port_q, rd_port_d;

  // Gather each port's request fields.
  always_comb begin
    port_req[PORT_PU]  = '{wr: wr0, addr: addr0, data: wdata0, attr: wattr0};
    port_req[PORT_DBG] = '{wr: wr1, addr: addr1, data: wdata1, attr: wattr1};
  end

  // A read of the address written last cycle would see stale data, so it sits out one cycle.
  always_comb begin
    hazard[PORT_PU]  = req0 & ~wr0 & pw_valid_q & (addr0 == pw_addr_q);
    hazard[PORT_DBG] = req1 & ~wr1 & pw_valid_q & (addr1 == pw_addr_q);
    // Nothing is granted during reset.
    elig = {req1, req0} & ~hazard & {2{~rst}};
  end

  pu_fram_rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .elig_i    (elig),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  assign sel     = port_req[gnt_idx];
  assign any_gnt = |gnt;
  assign ack0    = gnt[PORT_PU];
  assign ack1    = gnt[PORT_DBG];

  // Drive the FRAM command from the granted request; everything idles at zero otherwise.
  always_comb begin
    signal_addr  = '0;
    signal_wr    = 1'b0;
    signal_oe    = 1'b0;
    fram_data_in = '0;
    fram_attr_in = '0;
    if (any_gnt) begin
      signal_addr  = sel.addr;
      signal_wr    = sel.wr;
      signal_oe    = ~sel.wr;
      fram_data_in = sel.data;
      fram_attr_in = sel.attr;
    end
  end

  // Next state for write tracking and the read tag pipeline.
  always_comb begin
    pw_valid_d = any_gnt & sel.wr;
    pw_addr_d  = (any_gnt & sel.wr) ? sel.addr : pw_addr_q;
    rd_valid_d = any_gnt & ~sel.wr;
    rd_port_d  = any_gnt ? gnt_idx : rd_port_q;
  end

  // Write-tracking and read-tag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pw_valid_q <= 1'b0;
      pw_addr_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_port_q  <= 1'b0;
    end else begin
      pw_valid_q <= pw_valid_d;
      pw_addr_q  <= pw_addr_d;
      rd_valid_q <= rd_valid_d;
      rd_port_q  <= rd_port_d;
    end
  end

  // Route the FRAM read data to the port that issued the read; a response
  // pending across reset is dropped.
  always_comb begin
    rvalid0 = rd_valid_q & ~rst & (rd_port_q == PORT_PU);
    rvalid1 = rd_valid_q & ~rst & (rd_port_q == PORT_DBG);
    rdata0  = rvalid0 ? fram_data_out : '0;
    rattr0  = rvalid0 ? fram_attr_out : '0;
    rdata1  = rvalid1 ? fram_data_out : '0;
    rattr1  = rvalid1 ? fram_attr_out : '0;
  end

endmodule

// File: tb/tb_pu_fram_arbiter.sv
// Bench for pu_fram_arbiter: directed scenarios followed by random traffic,
// checked against a cycle-level reference model and a word-level memory image.
module tb_pu_fram_arbiter;

  localparam int RS  = 16;
  localparam int DW  = 32;
  localparam int TW  = 4;
  localparam int AW  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, wr0, req1, wr1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic [TW-1:0] wattr0, wattr1;
  logic          ack0, ack1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic [TW-1:0] rattr0, rattr1;
  logic [AW-1:0] signal_addr;
  logic          signal_wr, signal_oe;
  logic [DW-1:0] fram_data_in, fram_data_out;
  logic [TW-1:0] fram_attr_in, fram_attr_out;

  always #5 clk = ~clk;

  pu_fram_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .req0          (req0),
    .wr0           (wr0),
    .addr0         (addr0),
    .wdata0        (wdata0),
    .wattr0        (wattr0),
    .ack0          (ack0),
    .rvalid0       (rvalid0),
    .rdata0        (rdata0),
    .rattr0        (rattr0),
    .req1          (req1),
    .wr1           (wr1),
    .addr1         (addr1),
    .wdata1        (wdata1),
    .wattr1        (wattr1),
    .ack1          (ack1),
    .rvalid1       (rvalid1),
    .rdata1        (rdata1),
    .rattr1        (rattr1),
    .signal_addr   (signal_addr),
    .signal_wr     (signal_wr),
    .signal_oe     (signal_oe),
    .fram_data_in  (fram_data_in),
    .fram_attr_in  (fram_attr_in),
    .fram_data_out (fram_data_out),
    .fram_attr_out (fram_attr_out)
  );

  function automatic logic [DW-1:0] pat_data(input int i);
    return 32'hA5A50000 | DW'(i);
  endfunction
  function automatic logic [TW-1:0] pat_attr(input int i);
    return TW'(i) ^ 4'hA;
  endfunction

  // FRAM behaviour: command sampled at the edge, read data next cycle,
  // write committed one edge later. No reset.
  logic          init_mem;
  logic [DW-1:0] fmem [RS];
  logic [TW-1:0] famem [RS];
  logic          f_pw;
  logic [AW-1:0] f_pa;
  logic [DW-1:0] f_pd;
  logic [TW-1:0] f_pt;
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < RS; i++) begin
        fmem[i]  <= pat_data(i);
        famem[i] <= pat_attr(i);
      end
      f_pw          <= 1'b0;
      fram_data_out <= '0;
      fram_attr_out <= '0;
    end else begin
      if (f_pw) begin
        fmem[f_pa]  <= f_pd;
        famem[f_pa] <= f_pt;
      end
      f_pw <= signal_wr;
      f_pa <= signal_addr;
      f_pd <= fram_data_in;
      f_pt <= fram_attr_in;
      if (signal_oe) begin
        fram_data_out <= fmem[signal_addr];
        fram_attr_out <= famem[signal_addr];
      end
    end
  end

  int total = 0;
  int bad   = 0;

  // Reference model state: what the requesters should see.
  logic [DW-1:0] ref_mem  [RS];
  logic [TW-1:0] ref_attr [RS];
  logic          m_last;
  logic          m_prev_wr;
  logic [AW-1:0] m_prev_addr;
  logic          m_rsp;
  logic          m_rsp_port;
  logic [DW-1:0] m_rsp_data;
  logic [TW-1:0] m_rsp_attr;
  logic          m_g0, m_g1;

  // Observed DUT values sampled at the check point of the last cycle.
  logic          o_ack0, o_ack1, o_rv0, o_rv1, o_oe, o_wr;
  logic [DW-1:0] o_rd0, o_rd1;
  logic [TW-1:0] o_ra0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check DUT against the model at the falling edge, advance the model, move
  // to just after the next rising edge.
  task automatic cycle();
    logic          h0, h1, e0, e1, gv, g;
    logic          s_wr;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_data;
    logic [TW-1:0] s_attr;
    logic          rv0, rv1;
    @(negedge clk);
    o_ack0 = ack0; o_ack1 = ack1; o_rv0 = rvalid0; o_rv1 = rvalid1;
    o_rd0 = rdata0; o_rd1 = rdata1; o_ra0 = rattr0; o_oe = signal_oe; o_wr = signal_wr;
    gv = 1'b0;
    g  = 1'b0;
    if (!rst) begin
      h0 = req0 && !wr0 && m_prev_wr && (addr0 == m_prev_addr);
      h1 = req1 && !wr1 && m_prev_wr && (addr1 == m_prev_addr);
      e0 = req0 && !h0;
      e1 = req1 && !h1;
      gv = e0 || e1;
      if (e0 && e1) g = (m_last == 1'b1) ? 1'b0 : 1'b1;
      else          g = e0 ? 1'b0 : 1'b1;
    end
    m_g0   = gv && (g == 1'b0);
    m_g1   = gv && (g == 1'b1);
    s_wr   = g ? wr1 : wr0;
    s_addr = g ? addr1 : addr0;
    s_data = g ? wdata1 : wdata0;
    s_attr = g ? wattr1 : wattr0;
    check("ack0", ack0, m_g0);
    check("ack1", ack1, m_g1);
    check("signal_wr", signal_wr, gv && s_wr);
    check("signal_oe", signal_oe, gv && !s_wr);
    check("signal_addr", signal_addr, gv ? s_addr : '0);
    check("fram_data_in", fram_data_in, gv ? s_data : '0);
    check("fram_attr_in", fram_attr_in, gv ? s_attr : '0);
    rv0 = !rst && m_rsp && (m_rsp_port == 1'b0);
    rv1 = !rst && m_rsp && (m_rsp_port == 1'b1);
    check("rvalid0", rvalid0, rv0);
    check("rvalid1", rvalid1, rv1);
    check("rdata0", rdata0, rv0 ? m_rsp_data : '0);
    check("rattr0", rattr0, rv0 ? m_rsp_attr : '0);
    check("rdata1", rdata1, rv1 ? m_rsp_data : '0);
    check("rattr1", rattr1, rv1 ? m_rsp_attr : '0);
    if (rst) begin
      m_last    = 1'b1;
      m_prev_wr = 1'b0;
      m_rsp     = 1'b0;
    end else begin
      m_prev_wr = gv && s_wr;
      m_prev_addr = s_addr;
      m_rsp     = gv && !s_wr;
      m_rsp_port = g;
      m_rsp_data = ref_mem[s_addr];
      m_rsp_attr = ref_attr[s_addr];
      if (gv) m_last = g;
      if (gv && s_wr) begin
        ref_mem[s_addr]  = s_data;
        ref_attr[s_addr] = s_attr;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req0 = 1'b0; wr0 = 1'b0; addr0 = '0; wdata0 = '0; wattr0 = '0;
    req1 = 1'b0; wr1 = 1'b0; addr1 = '0; wdata1 = '0; wattr1 = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < RS; i++) begin
      ref_mem[i]  = pat_data(i);
      ref_attr[i] = pat_attr(i);
    end
    m_last = 1'b1; m_prev_wr = 1'b0; m_prev_addr = '0; m_rsp = 1'b0; m_rsp_port = 1'b0;
    m_rsp_data = '0; m_rsp_attr = '0;
    idle();
    init_mem = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    init_mem = 1'b0;
    do_reset();

    // 1: write then read of the same address stalls exactly one cycle.
    req0 = 1'b1; wr0 = 1'b1; addr0 = 4'd3; wdata0 = 32'hDEADBEEF; wattr0 = 4'h5;
    cycle();
    check("t1_wr_ack", o_ack0, 1'b1);
    wr0 = 1'b0;
    cycle();
    check("t1_stall", o_ack0, 1'b0);
    check("t1_stall_oe", o_oe, 1'b0);
    cycle();
    check("t1_rd_ack", o_ack0, 1'b1);
    idle();
    cycle();
    check("t1_rvalid", o_rv0, 1'b1);
    check("t1_rdata", o_rd0, 32'hDEADBEEF);
    check("t1_rattr", o_ra0, 4'h5);

    // 2: both ports reading continuously alternate, port 0 first after reset.
    do_reset();
    req0 = 1'b1; addr0 = 4'd1; req1 = 1'b1; addr1 = 4'd2;
    for (int i = 0; i < 8; i++) begin
      cycle();
      check("t2_ack0", o_ack0, (i % 2) == 0);
      check("t2_ack1", o_ack1, (i % 2) == 1);
      if (i > 0) check("t2_rv0", o_rv0, (i % 2) == 1);
    end
    idle();
    cycle();

    // 3: port 0 read hazarded behind port 1's write; port 1 read goes instead.
    req1 = 1'b1; wr1 = 1'b1; addr1 = 4'd7; wdata1 = 32'h12345678; wattr1 = 4'h3;
    cycle();
    check("t3_wr_ack1", o_ack1, 1'b1);
    wr1 = 1'b0; addr1 = 4'd4;
    req0 = 1'b1; addr0 = 4'd7;
    cycle();
    check("t3_stall0", o_ack0, 1'b0);
    check("t3_ack1", o_ack1, 1'b1);
    req1 = 1'b0;
    cycle();
    check("t3_ack0", o_ack0, 1'b1);
    check("t3_rv1", o_rv1, 1'b1);
    check("t3_rd1", o_rd1, pat_data(4));
    idle();
    cycle();
    check("t3_rv0", o_rv0, 1'b1);
    check("t3_rd0", o_rd0, 32'h12345678);

    // 4: idle cycles.
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("t4_oe", o_oe, 1'b0);
      check("t4_wr", o_wr, 1'b0);
      check("t4_rv", o_rv0 | o_rv1, 1'b0);
    end

    // 5: reset right after a port 1 read ack drops its response.
    req1 = 1'b1; addr1 = 4'd5;
    cycle();
    check("t5_ack1", o_ack1, 1'b1);
    idle();
    rst = 1'b1;
    cycle();
    check("t5_rv1_dropped", o_rv1, 1'b0);
    cycle();
    rst = 1'b0;
    req0 = 1'b1; addr0 = 4'd1; req1 = 1'b1; addr1 = 4'd2;
    cycle();
    check("t5_tie_ack0", o_ack0, 1'b1);
    check("t5_tie_ack1", o_ack1, 1'b0);
    idle();
    cycle();

    // 6: write then read of a different address does not stall.
    req0 = 1'b1; wr0 = 1'b1; addr0 = 4'd9; wdata0 = 32'hCAFEF00D; wattr0 = 4'h9;
    cycle();
    wr0 = 1'b0; addr0 = 4'd10;
    cycle();
    check("t6_no_stall", o_ack0, 1'b1);
    idle();
    cycle();
    check("t6_rvalid", o_rv0, 1'b1);
    check("t6_rdata", o_rd0, pat_data(10));

    // Random traffic over a small address window to provoke hazards; requests are held
    // until acked, with the occasional legal drop.
    for (int c = 0; c < 400; c++) begin
      if (!req0 || $urandom_range(0, 15) == 0) begin
        req0   = ($urandom_range(0, 3) != 0);
        wr0    = 1'($urandom_range(0, 1));
        addr0  = AW'($urandom_range(0, 3));
        wdata0 = $urandom;
        wattr0 = TW'($urandom_range(0, 15));
      end
      if (!req1 || $urandom_range(0, 15) == 0) begin
        req1   = ($urandom_range(0, 3) != 0);
        wr1    = 1'($urandom_range(0, 1));
        addr1  = AW'($urandom_range(0, 3));
        wdata1 = $urandom;
        wattr1 = TW'($urandom_range(0, 15));
      end
      rst = ($urandom_range(0, 99) == 0);
      cycle();
      if (m_g0) req0 = 1'b0;
      if (m_g1) req1 = 1'b0;
    end
    rst = 1'b0;
    idle();
    cycle();
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
